// File: rtl/sect571k1_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// sect571k1_pt_mul_arb
//
// Shares one sect571k1 point multiplier core between NUM_REQ requesters.
// A round-robin arbiter picks one scalar at a time, registers it, pulses the
// core start, waits for the core to finish and hands the registered (x, y)
// result back to the owning requester over a valid/ready handshake.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   clr           synchronous clear (also forwarded to the core as core_clr)
//   req_valid     per-requester request valid
//   req_ready     per-requester accept, one-hot or zero (combinational)
//   req_d         packed scalars, requester i at [i*M +: M]
//   rsp_valid     per-requester result valid, one-hot or zero
//   rsp_ready     per-requester result accept
//   rsp_x, rsp_y  registered result coordinates, shared by all requesters
//   rsp_id        index of the requester owning the current result
//   core_clr      clear to the core
//   core_start    one-cycle start pulse to the core
//   core_d        registered scalar to the core
//   core_done     core completion pulse
//   core_x/core_y core result coordinates
//   busy          high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module sect571k1_pt_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int M       = 571,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*M-1:0] req_d,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [M-1:0]         rsp_x,
  output logic [M-1:0]         rsp_y,
  output logic [IDW-1:0]       rsp_id,
  output logic                 core_clr,
  output logic                 core_start,
  output logic [M-1:0]         core_d,
  input  logic                 core_done,
  input  logic [M-1:0]         core_x,
  input  logic [M-1:0]         core_y,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester 0 gets first priority after reset/clear because the search
  // starts at last_id + 1.
  localparam logic [IDW-1:0] LAST_ID_INIT = IDW'(NUM_REQ - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDW-1:0]     r_last_id;
  logic [IDW-1:0]     r_rsp_id;
  logic [M-1:0]       r_core_d;
  logic [M-1:0]       r_rsp_x;
  logic [M-1:0]       r_rsp_y;

  logic               w_found;
  logic [IDW-1:0]     w_win_id;
  logic               w_grant;
  logic               w_rsp_take;

  // Round-robin search: first valid requester strictly after last_id, with
  // wrap-around.  The candidate sum is one bit wider so the wrap is a single
  // conditional subtract rather than a modulo.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW:0] cand;
    logic         hit;
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum      = {1'b0, r_last_id} + (IDW+1)'(i);
      cand     = (sum >= (IDW+1)'(NUM_REQ)) ? (sum - (IDW+1)'(NUM_REQ)) : sum;
      hit      = !w_found && req_valid[cand[IDW-1:0]];
      w_win_id = hit ? cand[IDW-1:0] : w_win_id;
      w_found  = w_found | hit;
    end
  end

  // A grant is only offered in IDLE and never in a clear cycle, so a
  // handshake can never complete while the block is being cleared.
  assign w_grant    = (r_state == ST_IDLE) && !clr && w_found;
  assign w_rsp_take = rsp_ready[r_rsp_id];

  // Next-state logic; clear overrides every state.
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = w_grant ? ST_START : ST_IDLE;
        ST_START: w_next = ST_BUSY;
        ST_BUSY:  w_next = core_done ? ST_RESP : ST_BUSY;
        ST_RESP:  w_next = w_rsp_take ? ST_IDLE : ST_RESP;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // State, arbitration pointer and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last_id <= LAST_ID_INIT;
      r_rsp_id  <= '0;
      r_core_d  <= '0;
      r_rsp_x   <= '0;
      r_rsp_y   <= '0;
    end else if (clr) begin
      r_state   <= ST_IDLE;
      r_last_id <= LAST_ID_INIT;
      r_rsp_id  <= '0;
      r_core_d  <= '0;
      r_rsp_x   <= '0;
      r_rsp_y   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_core_d  <= req_d[int'(w_win_id)*M +: M];
        r_last_id <= w_win_id;
        r_rsp_id  <= w_win_id;
      end
      // core_done outside BUSY is stale and must not disturb a held result.
      if ((r_state == ST_BUSY) && core_done) begin
        r_rsp_x <= core_x;
        r_rsp_y <= core_y;
      end
    end
  end

  assign req_ready  = w_grant ? (NUM_REQ'(1) << w_win_id) : '0;
  assign rsp_valid  = ((r_state == ST_RESP) && !clr) ? (NUM_REQ'(1) << r_rsp_id) : '0;
  assign core_start = (r_state == ST_START) && !clr;
  assign core_clr   = clr;
  assign core_d     = r_core_d;
  assign rsp_x      = r_rsp_x;
  assign rsp_y      = r_rsp_y;
  assign rsp_id     = r_rsp_id;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sect571k1_pt_mul_arb.sv
// -----------------------------------------------------------------------------
// Directed bench for sect571k1_pt_mul_arb.  A small stand-in core answers
// each start after a fixed latency with a result derived from the scalar;
// for d = 1 it returns the sect571k1 generator (XG, YG).
// -----------------------------------------------------------------------------
module tb_sect571k1_pt_mul_arb;

  localparam int NUM_REQ = 4;
  localparam int M       = 571;
  localparam int IDW     = 2;
  localparam int LAT     = 8;

  localparam logic [575:0] XG_FULL = 576'h026EB7A8_59923FBC_82189631_F8103FE4_AC9CA297_0012D5D4_60248048_01841CA4_43709584_93B205E6_47DA304D_B4CEB08C_BBD1BA39_494776FB_988B4717_4DCA88C7_E2945283_A01C8972;
  localparam logic [575:0] YG_FULL = 576'h0349DC80_7F4FBF37_4F4AEADE_3BCA9531_4DD58CEC_9F307A54_FFC61EFC_006D8A2C_9D4979C0_AC44AEA7_4FBEBBB9_F772AEDC_B620B01A_7BA7AF1B_320430C8_591984F6_01CD4C14_3EF1C7A3;
  localparam logic [M-1:0] XG = XG_FULL[M-1:0];
  localparam logic [M-1:0] YG = YG_FULL[M-1:0];

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clr = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*M-1:0] req_d = '0;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready = '0;
  logic [M-1:0]         rsp_x;
  logic [M-1:0]         rsp_y;
  logic [IDW-1:0]       rsp_id;
  logic                 core_clr;
  logic                 core_start;
  logic [M-1:0]         core_d;
  logic                 core_done = 1'b0;
  logic [M-1:0]         core_x = '1;
  logic [M-1:0]         core_y = '1;
  logic                 busy;

  int checks = 0;
  int failures = 0;

  int           stub_cnt = 0;
  logic [M-1:0] stub_d = '0;

  sect571k1_pt_mul_arb #(.NUM_REQ(NUM_REQ), .M(M), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_id(rsp_id),
    .core_clr(core_clr), .core_start(core_start), .core_d(core_d),
    .core_done(core_done), .core_x(core_x), .core_y(core_y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected core result for scalar d.
  function automatic logic [M-1:0] ex(input logic [M-1:0] d);
    return XG ^ (d - M'(1));
  endfunction
  function automatic logic [M-1:0] ey(input logic [M-1:0] d);
    return YG ^ ((d - M'(1)) << 3);
  endfunction

  // Stand-in core: done LAT cycles after start, result bus all-ones otherwise.
  always @(posedge clk) begin
    core_done <= 1'b0;
    core_x    <= '1;
    core_y    <= '1;
    if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        core_done <= 1'b1;
        core_x    <= ex(stub_d);
        core_y    <= ey(stub_d);
      end
    end else if (core_start) begin
      stub_cnt <= LAT;
      stub_d   <= core_d;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs one full job for requester k, which must win the next grant.
  task automatic serve(input int k, input logic [M-1:0] d);
    logic [NUM_REQ-1:0] exp_oh;
    int n;
    exp_oh = NUM_REQ'(1) << k;
    req_d[k*M +: M] = d;
    req_valid[k] = 1'b1;
    #1;
    checks++;
    if (req_ready !== exp_oh) begin
      failures++;
      $display("FAIL grant_req%0d: req_ready=%b expected %b", k, req_ready, exp_oh);
    end
    step();
    req_valid[k] = 1'b0;
    #1;
    checks++;
    if (core_start !== 1'b1 || core_d !== d || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_req%0d: core_start=%b busy=%b core_d=%h expected d=%h", k, core_start, busy, core_d, d);
    end
    step();
    checks++;
    if (core_start !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL busy_req%0d: core_start=%b req_ready=%b expected 0/0", k, core_start, req_ready);
    end
    n = 0;
    while (core_done !== 1'b1 && n < 30) begin
      checks++;
      if (rsp_valid !== '0) begin
        failures++;
        $display("FAIL early_rsp_req%0d: rsp_valid=%b expected 0", k, rsp_valid);
      end
      step();
      n++;
    end
    checks++;
    if (n >= 30) begin
      failures++;
      $display("FAIL done_timeout_req%0d: core_done not seen, waited %0d cycles", k, n);
    end
    step();
    checks++;
    if (rsp_valid !== exp_oh || rsp_id !== IDW'(k)) begin
      failures++;
      $display("FAIL rsp_valid_req%0d: rsp_valid=%b rsp_id=%0d expected %b/%0d", k, rsp_valid, rsp_id, exp_oh, k);
    end
    checks++;
    if (rsp_x !== ex(d) || rsp_y !== ey(d)) begin
      failures++;
      $display("FAIL rsp_xy_req%0d: x=%h y=%h expected x=%h", k, rsp_x, rsp_y, ex(d));
    end
    rsp_ready = exp_oh;
    step();
    rsp_ready = '0;
    #1;
    checks++;
    if (rsp_valid !== '0 || busy !== 1'b0 || rsp_x !== ex(d)) begin
      failures++;
      $display("FAIL release_req%0d: rsp_valid=%b busy=%b x=%h", k, rsp_valid, busy, rsp_x);
    end
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0 || core_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: rsp_valid=%b req_ready=%b core_start=%b busy=%b expected 0", rsp_valid, req_ready, core_start, busy);
    end
    checks++;
    if (rsp_x !== '0 || rsp_y !== '0 || rsp_id !== '0 || core_d !== '0) begin
      failures++;
      $display("FAIL reset_data: rsp_x=%h rsp_id=%0d core_d=%h expected 0", rsp_x, rsp_id, core_d);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    serve(2, M'(1));
    checks++;
    if (rsp_x !== XG || rsp_y !== YG) begin
      failures++;
      $display("FAIL single_generator: x=%h expected %h", rsp_x, XG);
    end
  endtask

  task automatic test_all_four();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) req_d[k*M +: M] = M'(k + 1);
    req_valid = 4'b1111;
    for (int k = 0; k < NUM_REQ; k++) serve(k, M'(k + 1));
  endtask

  task automatic test_fairness();
    req_d[1*M +: M] = M'(6);
    req_valid = 4'b0011;
    serve(0, M'(5));
    req_valid[0] = 1'b1;
    serve(1, M'(6));
    serve(0, M'(7));
  endtask

  task automatic test_back_pressure();
    int n;
    req_d[1*M +: M] = M'(9);
    req_d[2*M +: M] = M'(10);
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_grant: req_ready=%b expected 0010", req_ready);
    end
    step();
    req_valid[1] = 1'b0;
    n = 0;
    while (core_done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (n >= 30) begin
      failures++;
      $display("FAIL bp_done_timeout: waited %0d cycles", n);
    end
    step();
    rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0010 || req_ready !== '0 || core_start !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_ctrl cyc%0d: rsp_valid=%b req_ready=%b core_start=%b", c, rsp_valid, req_ready, core_start);
      end
      checks++;
      if (rsp_x !== ex(M'(9)) || rsp_y !== ey(M'(9))) begin
        failures++;
        $display("FAIL bp_hold_data cyc%0d: x=%h expected %h", c, rsp_x, ex(M'(9)));
      end
      step();
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    serve(2, M'(10));
  endtask

  task automatic test_clear();
    req_d[3*M +: M] = M'(11);
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL clr_grant: req_ready=%b expected 1000", req_ready);
    end
    step();
    req_valid = '0;
    for (int c = 0; c < 5; c++) step();
    clr = 1'b1;
    #1;
    checks++;
    if (core_clr !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_forward: core_clr=%b busy=%b expected 1/1", core_clr, busy);
    end
    step();
    clr = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== '0 || core_d !== '0 || rsp_x !== '0 || rsp_id !== '0) begin
      failures++;
      $display("FAIL clr_state: busy=%b rsp_valid=%b core_d=%h rsp_id=%0d", busy, rsp_valid, core_d, rsp_id);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (rsp_valid !== '0 || busy !== 1'b0 || rsp_x !== '0) begin
        failures++;
        $display("FAIL clr_late_done cyc%0d: rsp_valid=%b busy=%b rsp_x=%h", c, rsp_valid, busy, rsp_x);
      end
    end
    req_d[2*M +: M] = M'(13);
    req_valid = 4'b0101;
    serve(0, M'(12));
    serve(2, M'(13));
  endtask

  task automatic test_async_reset();
    int n;
    req_d[1*M +: M] = M'(14);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL rst_grant: req_ready=%b expected 0010", req_ready);
    end
    step();
    req_valid = '0;
    n = 0;
    while (core_done !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0010) begin
      failures++;
      $display("FAIL rst_in_resp: rsp_valid=%b expected 0010", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== '0 || req_ready !== '0 || core_start !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_ctrl: rsp_valid=%b req_ready=%b core_start=%b busy=%b", rsp_valid, req_ready, core_start, busy);
    end
    checks++;
    if (rsp_x !== '0 || rsp_y !== '0 || rsp_id !== '0 || core_d !== '0) begin
      failures++;
      $display("FAIL rst_data: rsp_x=%h rsp_id=%0d core_d=%h expected 0", rsp_x, rsp_id, core_d);
    end
    step();
    rst_n = 1'b1;
    req_d[2*M +: M] = M'(16);
    req_valid = 4'b0101;
    serve(0, M'(15));
    serve(2, M'(16));
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_back_pressure();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sect571k1_pt_mul_arb.md
# sect571k1_pt_mul_arb

Round-robin arbiter and sequencer that shares a single sect571k1 point multiplier core between NUM_REQ independent requesters. It accepts one scalar at a time, registers it, pulses the core start, waits for completion, and returns the registered (x, y) result to the granted requester over a valid/ready handshake. It sits between the system-level request sources and the sect571k1 point multiplication core, whose start/done/d/x/y ports it drives directly.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- M, 571, field degree / scalar and coordinate width
- IDW, 2, requester index width, equal to clog2(NUM_REQ)
- clk  input  1  system clock
- rst_n  input  1  system asynchronous reset, active low
- clr  input  1  synchronous clear
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
- req_d  input  NUM_REQ*M  scalars; requester i occupies bits [i*M +: M]
- rsp_valid  output  NUM_REQ  per-requester result valid, one-hot or zero
- rsp_ready  input  NUM_REQ  per-requester result accept
- rsp_x  output  M  result x coordinate, shared by all requesters
- rsp_y  output  M  result y coordinate, shared by all requesters
- rsp_id  output  IDW  index of the requester that owns the current result
- core_clr  output  1  clear forwarded to the core, equal to clr
- core_start  output  1  core start pulse
- core_d  output  M  registered scalar to the core
- core_done  input  1  core completion pulse
- core_x  input  M  core result x
- core_y  input  M  core result y
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, START, BUSY, RESP.
- IDLE: round-robin grant over req_valid, searching from last_id+1 upward with wrap-around. req_ready is asserted combinationally for the winner only. On req_valid & req_ready: latch the winner's req_d into core_d, set last_id and rsp_id to the winner, and go to START.
- START: core_start = 1 for exactly one cycle, then go to BUSY.
- BUSY: wait for core_done. core_done is ignored in every other state. On core_done: register core_x and core_y into rsp_x and rsp_y, and go to RESP.
- RESP: rsp_valid[rsp_id] = 1. Once rsp_ready[rsp_id] is high, go to IDLE. rsp_ready on other bits is ignored.
- Requests arriving while the block is not in IDLE are not accepted. They stay pending, and requesters must hold req_valid and req_d stable until accepted.
- last_id resets to NUM_REQ-1, so requester 0 has first priority after reset.
- A requester that reasserts immediately after its response does not win again while any other requester is valid (fairness).
- rsp_x, rsp_y and rsp_id hold their values after RESP until the next result is written.
- clr, synchronous, any state: next state is IDLE, core_start = 0, rsp_valid = 0, last_id = NUM_REQ-1, data registers are zeroed. A job in flight is discarded and its requester gets no response. core_clr carries clr to the core in the same cycle.
- rst_n low, any state: asynchronously returns the FSM to IDLE with the same register values as clr.

## Timing
- Reset/clr values: req_ready = 0 until the first IDLE evaluation, rsp_valid = 0, rsp_x = 0, rsp_y = 0, rsp_id = 0, core_start = 0, core_d = 0, busy = 0.
- Request accepted in cycle T → core_start high in T+1 (START) with core_d already valid.
- core_done in cycle D → rsp_valid high from D+1.
- rsp_ready high in cycle R → rsp_valid low in R+1, and the next grant can occur in R+1.
- Arbitration overhead is 3 cycles plus core latency plus the response wait.
- core_done arriving in the same cycle as clr: clr wins and no response is produced.
- No request is ever accepted in the same cycle as clr.

## Test plan
- Single request: requester 2 sends d=1 → core_start pulses 1 cycle after acceptance; rsp_valid[2] rises 1 cycle after core_done; rsp_x/rsp_y equal the sect571k1 generator XG/YG; rsp_id=2.
- All 4 requesters hold req_valid after reset with d=1,2,3,4 → grant order 0,1,2,3; each result matches its d·G, computed by the reference model.
- Fairness: requester 0 reasserts right after its response while 1 is pending → 1 is granted next, then 0.
- Backpressure: hold rsp_ready[1]=0 for 20 cycles → rsp_valid[1], rsp_x and rsp_y are stable; no new grant happens; req_ready stays 0.
- clr asserted 5 cycles into BUSY → next cycle IDLE, rsp_valid=0; late core_done ignored; a new request is granted normally and returns the correct result.
- rst_n pulsed low in RESP → all outputs at reset values immediately; after release, requester 0 wins a contested grant.
